lockin_result_packer: RTL and testbench
=======================================

Name: lockin_result_packer

Overview:
- Sits directly downstream of the lock-in signal-processing stage.
- Consumes its two 64-bit signed result streams, in-phase (fase) and quadrature (cuad).
- Pairs each fase sample with its cuad sample and buffers the pairs in a FIFO.
- Serialises each pair into four 32-bit words on a ready/valid stream for the HPS/DMA readout path. Tracks drops and pairing errors.

Parameters:
- DEPTH, 16, FIFO capacity in fase/cuad pairs; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, new input samples are ignored; already-buffered data still drains.
- clear  in  1  synchronous flush of holding registers, FIFO, serializer and status.
- fase_in  in  64  signed in-phase result.
- fase_valid  in  1  one-cycle qualifier for fase_in.
- cuad_in  in  64  signed quadrature result.
- cuad_valid  in  1  one-cycle qualifier for cuad_in.
- out_data  out  32  serialised word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the word when out_valid && out_ready.
- out_sop  out  1  high on word 0 of each pair.
- pairs_stored  out  ADDR_W+1  number of pairs in the FIFO, excluding the pair being serialised.
- dropped_count  out  32  pairs lost to FIFO full; saturates at 0xFFFFFFFF.
- overflow  out  1  sticky; set on the first drop.
- pair_error  out  1  sticky; set when a second sample arrives on one channel before its partner.

Behaviour:
- Reset values (async reset_n=0): out_data=0, out_valid=0, out_sop=0, pairs_stored=0, dropped_count=0, overflow=0, pair_error=0. Holding registers empty, FIFO pointers 0, word index 0.
- clear=1 at an edge: same state as reset on the next cycle. clear has priority over all other events in that cycle. Inputs arriving with clear are discarded.
- Pairing stage: holds fase_h/fase_full and cuad_h/cuad_full. Inputs are captured only when enable=1.
  - Both valids in the same cycle: pair completes immediately.
  - Only one valid: capture into its holding register. The pair completes when the partner arrives, from either side.
  - Valid on a channel whose holding register is already full, with no partner this cycle: overwrite the held value and set pair_error.
  - Pair complete: both holding registers clear in the same cycle; the push request is registered.
- Push: the 128-bit word {cuad,fase} is written one cycle after pair completion.
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the pair is discarded, dropped_count increments (saturating), and overflow is set.
- Serializer FSM, states IDLE and SEND:
  - IDLE: if the FIFO is non-empty, pop into a 128-bit shift register, set word index 0, go to SEND. out_valid asserts the following cycle.
  - SEND: out_data word order is fase[31:0], fase[63:32], cuad[31:0], cuad[63:32]. out_sop=1 only at index 0.
  - Index advances only on out_valid && out_ready. out_data and out_valid are held stable while out_ready=0.
  - On acceptance of index 3: if the FIFO is non-empty, pop and restart at index 0 with no bubble (back-to-back pairs). Otherwise go to IDLE with out_valid=0.
- Latency: second input valid at cycle t → FIFO write at t+1 → out_valid=1 with word 0 at t+3 when the path is empty. Sustained throughput is 1 pair per 4 accepted words.
- Simultaneous push and pop with the FIFO full: both proceed and the count is unchanged.
- enable falling mid-pair: the held half remains until a partner arrives with enable=1, or until clear.
- Arithmetic: pure data movement; no sign extension or truncation. The 64-bit values are split bit-exactly.

Decomposition:
- Shared package holds: word-index encoding (WORD_FASE_LO=0 … WORD_CUAD_HI=3), FSM state encodings (IDLE, SEND), PAIR_W=128.
- One natural sub-module: sync_fifo_fwft (parameterised width and depth, with full, empty and count), reused by other readout blocks.
- Pairing logic and the serializer stay in the top module.

Test Plan:
- Simultaneous valids, fase=0x0000000100000002, cuad=0xFFFFFFFFFFFFFFFE, out_ready=1 → words 0x00000002, 0x00000001, 0xFFFFFFFE, 0xFFFFFFFF; out_sop only on the first; out_valid first high 3 cycles after input.
- fase at cycle 0, cuad at cycle 5 → a single pair is emitted, pair_error=0. Then fase at cycles 10 and 12 and cuad at 14 → pair_error=1; the emitted fase equals the cycle-12 value.
- out_ready=0, 20 pairs pushed with DEPTH=16 → pairs_stored=16, dropped_count=3 (one pair sits in the serializer), overflow=1. After releasing out_ready, exactly 17×4 words drain in order.
- out_ready toggling 1,0,1,0 during a pair → out_data and out_valid stable while stalled; no word duplicated or skipped.
- Two pairs queued, out_ready=1 → 8 consecutive out_valid cycles with no bubble between word 3 and the next word 0.
- Assert reset_n low mid-serialisation (word index 2) and separately pulse clear → all outputs return to reset values immediately (reset) or on the next cycle (clear); the FIFO is empty and status is cleared.

Source files
------------

// File: rtl/lockin_result_packer_pkg.sv
// rtl/lockin_result_packer_pkg.sv - shared widths and encodings for the lock-in result packer
package lockin_result_packer_pkg;

  localparam int SAMPLE_W = 64;
  localparam int WORD_W   = 32;
  localparam int PAIR_W   = 128;

  typedef enum logic [1:0] {
    WORD_FASE_LO = 2'd0,
    WORD_FASE_HI = 2'd1,
    WORD_CUAD_LO = 2'd2,
    WORD_CUAD_HI = 2'd3
  } word_idx_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/lockin_result_packer_if.sv
// rtl/lockin_result_packer_if.sv - sample inputs and serialised word stream of the packer
interface lockin_result_packer_if;
  import lockin_result_packer_pkg::*;

  logic [SAMPLE_W-1:0] fase_in;
  logic                fase_valid;
  logic [SAMPLE_W-1:0] cuad_in;
  logic                cuad_valid;
  logic [WORD_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_sop;

  modport master (
    output fase_in, fase_valid, cuad_in, cuad_valid, out_ready,
    input  out_data, out_valid, out_sop
  );

  modport slave (
    input  fase_in, fase_valid, cuad_in, cuad_valid, out_ready,
    output out_data, out_valid, out_sop
  );

endinterface

// File: rtl/lockin_result_packer_sync_fifo_fwft.sv
// rtl/lockin_result_packer_sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO with count
module sync_fifo_fwft #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_wr_en,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A write into a full FIFO is legal when the head leaves in the same cycle.
  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/lockin_result_packer.sv
// rtl/lockin_result_packer.sv - pairs fase/cuad results, buffers them and serialises 4 words per pair
module lockin_result_packer
  import lockin_result_packer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  lockin_result_packer_if.slave bus,
  output logic [ADDR_W:0]       pairs_stored,
  output logic [31:0]           dropped_count,
  output logic                  overflow,
  output logic                  pair_error
);

  logic [SAMPLE_W-1:0] r_fase_h, r_cuad_h;
  logic                r_fase_full, r_cuad_full;
  logic                r_push_vld;
  logic [PAIR_W-1:0]   r_push_data;
  logic                r_pair_error;
  logic [31:0]         r_dropped;
  logic                r_overflow;
  logic [PAIR_W-1:0]   r_shift;
  word_idx_e           r_idx;
  ser_state_e          r_state, w_state_nxt;

  logic                w_fv, w_cv, w_complete, w_pair_err;
  logic [SAMPLE_W-1:0] w_pair_fase, w_pair_cuad;
  logic [PAIR_W-1:0]   w_fifo_data;
  logic                w_fifo_full, w_fifo_empty;
  logic                w_last_acc, w_pop, w_drop;

  assign w_fv        = enable && bus.fase_valid;
  assign w_cv        = enable && bus.cuad_valid;
  assign w_complete  = (w_fv && w_cv) || (w_fv && r_cuad_full) || (w_cv && r_fase_full);
  assign w_pair_fase = w_fv ? bus.fase_in : r_fase_h;
  assign w_pair_cuad = w_cv ? bus.cuad_in : r_cuad_h;
  assign w_pair_err  = (w_fv && !w_cv && r_fase_full) || (w_cv && !w_fv && r_cuad_full);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear) begin
      r_fase_h     <= '0;
      r_cuad_h     <= '0;
      r_fase_full  <= 1'b0;
      r_cuad_full  <= 1'b0;
      r_push_vld   <= 1'b0;
      r_push_data  <= '0;
      r_pair_error <= 1'b0;
    end else begin
      r_push_vld <= w_complete;
      if (w_complete) begin
        r_push_data <= {w_pair_cuad, w_pair_fase};
        r_fase_full <= 1'b0;
        r_cuad_full <= 1'b0;
      end else begin
        if (w_fv) begin
          r_fase_h    <= bus.fase_in;
          r_fase_full <= 1'b1;
        end
        if (w_cv) begin
          r_cuad_h    <= bus.cuad_in;
          r_cuad_full <= 1'b1;
        end
      end
      if (w_pair_err) r_pair_error <= 1'b1;
    end
  end

  sync_fifo_fwft #(.WIDTH(PAIR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_clear   (clear),
    .i_wr_en   (r_push_vld),
    .i_wr_data (r_push_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (pairs_stored)
  );

  assign w_last_acc = (r_state == SEND) && bus.out_ready && (r_idx == WORD_CUAD_HI);
  assign w_pop      = !w_fifo_empty && ((r_state == IDLE) || w_last_acc);
  assign w_drop     = r_push_vld && w_fifo_full && !w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear) r_state <= IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_fifo_empty) w_state_nxt = SEND;
      SEND:    if (w_last_acc && w_fifo_empty) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Words leave from the bottom of the shift register, so it reads zero once a pair drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear) begin
      r_shift <= '0;
      r_idx   <= WORD_FASE_LO;
    end else if (w_pop) begin
      r_shift <= w_fifo_data;
      r_idx   <= WORD_FASE_LO;
    end else if ((r_state == SEND) && bus.out_ready) begin
      r_shift <= {WORD_W'(0), r_shift[PAIR_W-1:WORD_W]};
      r_idx   <= word_idx_e'(r_idx + 2'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear) begin
      r_dropped  <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      if (r_dropped != '1) r_dropped <= r_dropped + 1'b1;
      r_overflow <= 1'b1;
    end
  end

  assign bus.out_data   = r_shift[WORD_W-1:0];
  assign bus.out_valid  = (r_state == SEND);
  assign bus.out_sop    = (r_state == SEND) && (r_idx == WORD_FASE_LO);
  assign dropped_count  = r_dropped;
  assign overflow       = r_overflow;
  assign pair_error     = r_pair_error;

endmodule

// File: tb/tb_lockin_result_packer.sv
// tb/tb_lockin_result_packer.sv - directed and randomized bench for lockin_result_packer
module tb_lockin_result_packer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              clear;
  logic [ADDR_W:0]   pairs_stored;
  logic [31:0]       dropped_count;
  logic              overflow;
  logic              pair_error;

  lockin_result_packer_if bus ();

  lockin_result_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .clear         (clear),
    .bus           (bus),
    .pairs_stored  (pairs_stored),
    .dropped_count (dropped_count),
    .overflow      (overflow),
    .pair_error    (pair_error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_words  = 0;
  int          rdy_mode = 0;
  logic        mon_en   = 1'b0;
  logic        exp_perr = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [63:0] f, input logic [63:0] c);
    exp_q.push_back({1'b1, f[31:0]});
    exp_q.push_back({1'b0, f[63:32]});
    exp_q.push_back({1'b0, c[31:0]});
    exp_q.push_back({1'b0, c[63:32]});
  endtask

  task automatic drive(input logic fv, input logic [63:0] f, input logic cv, input logic [63:0] c);
    bus.fase_valid = fv;
    bus.fase_in    = f;
    bus.cuad_valid = cv;
    bus.cuad_in    = c;
    @(posedge clk); #1;
    bus.fase_valid = 1'b0;
    bus.cuad_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (!(exp_q.size() == 0 && !bus.out_valid && pairs_stored == '0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 64'(k >= 3000), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_data"},    64'(bus.out_data),  64'd0);
    check({tag, "_valid"},   64'(bus.out_valid), 64'd0);
    check({tag, "_sop"},     64'(bus.out_sop),   64'd0);
    check({tag, "_stored"},  64'(pairs_stored),  64'd0);
    check({tag, "_dropped"}, 64'(dropped_count), 64'd0);
    check({tag, "_ovf"},     64'(overflow),      64'd0);
    check({tag, "_perr"},    64'(pair_error),    64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Each pair is generated with a known delivery pattern, so its expected content is known up front.
  task automatic rand_batch(input int npairs);
    logic [63:0] f, c, f0;
    int kind;
    for (int i = 0; i < npairs; i++) begin
      f = rnd64();
      c = rnd64();
      kind = $urandom_range(0, 3);
      push_pair(f, c);
      case (kind)
        0: drive(1'b1, f, 1'b1, c);
        1: begin drive(1'b1, f, 1'b0, '0); idle($urandom_range(0, 3)); drive(1'b0, '0, 1'b1, c); end
        2: begin drive(1'b0, '0, 1'b1, c); idle($urandom_range(0, 3)); drive(1'b1, f, 1'b0, '0); end
        default: begin
          f0 = rnd64();
          drive(1'b1, f0, 1'b0, '0);
          idle($urandom_range(0, 2));
          drive(1'b1, f, 1'b0, '0);
          idle($urandom_range(0, 2));
          drive(1'b0, '0, 1'b1, c);
          exp_perr = 1'b1;
        end
      endcase
      idle($urandom_range(0, 2));
    end
    wait_drain();
    check("rand_perr",    64'(pair_error),    64'(exp_perr));
    check("rand_dropped", 64'(dropped_count), 64'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (prev_stall) begin
        check("stall_data",  64'(bus.out_data),  64'(prev_data));
        check("stall_valid", 64'(bus.out_valid), 64'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_words++;
        if (exp_q.size() == 0) begin
          check("extra_word", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("word", 64'(bus.out_data), 64'(mon_e[31:0]));
          check("sop",  64'(bus.out_sop),  64'(mon_e[32]));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1)      bus.out_ready = ($urandom_range(0, 3) != 0);
      else if (rdy_mode == 2) bus.out_ready = !bus.out_ready;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] f, c, a1, a2;
    int snap, run;
    bus.fase_in = '0; bus.fase_valid = 1'b0;
    bus.cuad_in = '0; bus.cuad_valid = 1'b0;
    bus.out_ready = 1'b0;
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Simultaneous valids, latency and word order.
    bus.out_ready = 1'b1;
    f = 64'h0000000100000002;
    c = 64'hFFFFFFFFFFFFFFFE;
    push_pair(f, c);
    drive(1'b1, f, 1'b1, c);
    check("lat_c1", 64'(bus.out_valid), 64'd0);
    idle(1);
    check("lat_c2", 64'(bus.out_valid), 64'd0);
    idle(1);
    check("lat_c3", 64'(bus.out_valid), 64'd1);
    check("t1_sop", 64'(bus.out_sop),   64'd1);
    check("t1_w0",  64'(bus.out_data),  64'h00000002);
    wait_drain();

    // Split arrival, then a duplicated fase.
    f = rnd64(); c = rnd64();
    push_pair(f, c);
    drive(1'b1, f, 1'b0, '0);
    idle(4);
    drive(1'b0, '0, 1'b1, c);
    wait_drain();
    check("t2_perr0", 64'(pair_error), 64'd0);
    a1 = rnd64(); a2 = rnd64(); c = rnd64();
    push_pair(a2, c);
    drive(1'b1, a1, 1'b0, '0);
    idle(1);
    drive(1'b1, a2, 1'b0, '0);
    idle(1);
    drive(1'b0, '0, 1'b1, c);
    wait_drain();
    exp_perr = 1'b1;
    check("t2_perr1", 64'(pair_error), 64'd1);

    // Overflow with the sink stalled.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      f = rnd64(); c = rnd64();
      if (i < 17) push_pair(f, c);
      drive(1'b1, f, 1'b1, c);
    end
    idle(4);
    check("t3_stored",  64'(pairs_stored),  64'd16);
    check("t3_dropped", 64'(dropped_count), 64'd3);
    check("t3_ovf",     64'(overflow),      64'd1);
    snap = n_words;
    bus.out_ready = 1'b1;
    wait_drain();
    check("t3_words", 64'(n_words - snap), 64'd68);

    // Clear flushes FIFO, serializer, holding registers and status.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 18; i++) drive(1'b1, rnd64(), 1'b1, rnd64());
    drive(1'b1, rnd64(), 1'b0, '0);
    idle(3);
    check("clr_pre_stored", 64'(pairs_stored), 64'd16);
    mon_en = 1'b0;
    clear = 1'b1;
    drive(1'b1, rnd64(), 1'b1, rnd64());
    clear = 1'b0;
    check_reset("clear");
    exp_perr = 1'b0;
    mon_en = 1'b1;
    idle(3);
    check("clr_in_discard", 64'(pairs_stored), 64'd0);
    f = rnd64(); c = rnd64();
    push_pair(f, c);
    drive(1'b0, '0, 1'b1, c);
    drive(1'b1, f, 1'b0, '0);
    bus.out_ready = 1'b1;
    wait_drain();
    check("clr_perr", 64'(pair_error), 64'd0);

    // enable gating, including a partner ignored while disabled.
    enable = 1'b0;
    drive(1'b1, rnd64(), 1'b1, rnd64());
    idle(3);
    check("en_off_stored", 64'(pairs_stored),  64'd0);
    check("en_off_valid",  64'(bus.out_valid), 64'd0);
    enable = 1'b1;
    f = rnd64(); c = rnd64();
    push_pair(f, c);
    drive(1'b1, f, 1'b0, '0);
    enable = 1'b0;
    drive(1'b0, '0, 1'b1, rnd64());
    enable = 1'b1;
    idle(1);
    drive(1'b0, '0, 1'b1, c);
    wait_drain();

    // Randomized traffic with a random sink.
    rdy_mode = 1;
    for (int b = 0; b < 4; b++) rand_batch($urandom_range(4, 12));
    rdy_mode = 0;

    // Back-to-back pairs: 8 valid words with no bubble.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      f = rnd64(); c = rnd64();
      push_pair(f, c);
      drive(1'b1, f, 1'b1, c);
    end
    idle(4);
    check("b2b_stored", 64'(pairs_stored), 64'd1);
    bus.out_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid && run == i) run++;
    end
    check("b2b_run", 64'(run), 64'd8);
    wait_drain();

    // Alternating ready during a pair.
    bus.out_ready = 1'b0;
    f = rnd64(); c = rnd64();
    push_pair(f, c);
    drive(1'b1, f, 1'b1, c);
    idle(4);
    rdy_mode = 2;
    wait_drain();
    rdy_mode = 0;

    // Async reset at word index 2.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      f = rnd64(); c = rnd64();
      push_pair(f, c);
      drive(1'b1, f, 1'b1, c);
    end
    idle(4);
    bus.out_ready = 1'b1;
    idle(2);
    bus.out_ready = 1'b0;
    check("rst_mid_valid", 64'(bus.out_valid), 64'd1);
    mon_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    exp_q.delete();
    exp_perr = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    check_reset("rst_after");

    rdy_mode = 1;
    rand_batch(8);
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
